irq_controller: RTL and testbench
=================================

# irq_controller

Machine-level external interrupt controller sitting directly upstream of the CSR controller. Samples up to 16 level-sensitive platform interrupt lines, masks them with the `mie` value the CSR controller exports, and selects one by fixed priority. At an instruction boundary it raises the single-cycle trap strobe and the cause word the CSR controller latches into `mepc`/`mcause`. It then blocks further interrupts until `mret`.

## Interface
- `N_IRQ`, default 16: number of platform interrupt lines; legal range 1..16.
- `clk_i  in  1`: single clock; all state on rising edge.
- `rst_ni  in  1`: reset, asynchronous, active-low.
- `irq_req_i  in  N_IRQ`: level-sensitive interrupt requests; bit k is platform interrupt k.
- `mie_i  in  32`: `mie` CSR value; bit 16+k enables line k; other bits ignored.
- `ready_i  in  1`: core is at an instruction boundary and can take a trap this cycle.
- `mret_i  in  1`: `mret` retiring this cycle.
- `trap_o  out  1`: trap strobe to the CSR controller `trap_i`; high for exactly one cycle per accepted interrupt.
- `irq_cause_o  out  32`: cause word to the CSR controller `mcause_i`; valid whenever `trap_o`=1.
- `irq_ack_o  out  N_IRQ`: one-hot acknowledge to the peripheral, pulsed in the same cycle as `trap_o`.
- `busy_o  out  1`: high when state ≠ IDLE.

## Operation
- Sampled request: `s_req` = `irq_req_i` (raw), or the synchronizer output (see Configuration).
- Masked vector: `pend` = `s_req & mie_i[16+N_IRQ-1:16]`.
- Priority: lowest index wins. Winner index `k` is 4 bits.
- Cause encoding: `irq_cause_o` = {1'b1, 26'b0, 5'(16+k)}.
  - k=0 gives 32'h8000_0010.
  - k=15 gives 32'h8000_001F.
- FSM states and transitions:
  - IDLE:
    - If `pend` ≠ 0, register winner `k` and its cause, then go to REQ.
    - Otherwise stay in IDLE.
  - REQ, winner still valid (`pend[k]`=1):
    - If `ready_i`=1: `trap_o`=1, `irq_ack_o`=1<<k, go to SERVICE.
    - If `ready_i`=0: hold in REQ. The winner is not re-arbitrated even if a higher-priority line rises.
  - REQ, winner invalid (`pend[k]`=0, either deasserted or masked):
    - Withdraw: no trap, no ack, return to IDLE.
    - This check takes precedence over `ready_i`.
  - SERVICE:
    - Stay until `mret_i`=1, then go to IDLE.
    - Requests arriving meanwhile are not lost; they are re-arbitrated from IDLE because they are level-sensitive.
    - Nesting is not supported.
- `mret_i` is ignored outside SERVICE.
- `trap_o` and `irq_ack_o` are decoded combinationally from the registered state plus `ready_i` and `pend[k]`. They never assert in IDLE or SERVICE.
- `irq_cause_o` is registered. It holds its last captured value outside REQ.
- Reset asserted at any time:
  - Immediate return to IDLE.
  - Cause register and synchronizer flops cleared.
  - Any in-flight REQ is dropped silently.
- Reset values: `trap_o`=0, `irq_cause_o`=32'h0, `irq_ack_o`=0, `busy_o`=0.

## Timing
- Without sync, request-to-REQ latency is 1 cycle:
  - `pend` is seen at edge n, state is REQ after edge n.
  - The earliest `trap_o` is in cycle n+1, when `ready_i`=1.
- With sync, add 2 cycles: earliest `trap_o` is in cycle n+3.
- `trap_o` to SERVICE takes 1 edge. `mret_i` to IDLE takes 1 edge.
- Earliest next `trap_o` after `mret_i` is 2 cycles later, if a request is still pending.
- Throughput: at most one interrupt per `mret` round trip.

## Configuration
- `IRQ_SYNC_EN` defined:
  - Each `irq_req_i` bit passes through a 2-flop synchronizer, reset to 0.
  - `s_req` is the second-stage output.
  - Intended for lines from asynchronous domains.
- `IRQ_SYNC_EN` undefined:
  - `s_req` = `irq_req_i` directly.
  - Lines must be synchronous to `clk_i`.
  - No synchronizer flops are present.
- All other behaviour is identical in both builds; only latency shifts by +2.

## Test plan
- Reset: drive `rst_ni`=0 mid-REQ (line 3 pending, `ready_i`=0) → `busy_o`, `trap_o`, `irq_ack_o` = 0 and `irq_cause_o`=0 immediately; after release no trap until re-sampled.
- Basic: `mie_i`=32'h0001_0000, `irq_req_i`[0]=1, `ready_i`=1 → `trap_o` one cycle, `irq_cause_o`=32'h8000_0010, `irq_ack_o`=16'h0001; `busy_o` stays 1 until `mret_i`.
- Priority/mask: lines 2 and 5 high, `mie_i`=32'h0024_0000 → cause 32'h8000_0012; clear `mie_i` bit 18 → cause 32'h8000_0015.
- Stall then withdraw: line 7 enabled, `ready_i`=0 for 4 cycles, then drop line 7 → no `trap_o`, return to IDLE; with line 1 rising during the stall, no switch to 1 before the withdraw.
- Blocking: second line asserted during SERVICE → no `trap_o` until `mret_i`; `trap_o` follows 2 cycles after `mret_i` with the correct cause.
- Sync build: with `IRQ_SYNC_EN` defined and `ready_i`=1, `trap_o` appears exactly 2 cycles later than in the unsynchronized build for the same stimulus.

Source files
------------

// File: rtl/irq_controller_if.sv
// ============================================================================
// Module   : irq_controller_if
// Brief    : Request/trap bundle between platform interrupt lines, the core
//            and the CSR controller, as seen by irq_controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface irq_controller_if #(
   parameter int N_IRQ = 16
) ();
   logic [N_IRQ-1:0] irq_req_i;
   logic [31:0]      mie_i;
   logic             ready_i;
   logic             mret_i;
   logic             trap_o;
   logic [31:0]      irq_cause_o;
   logic [N_IRQ-1:0] irq_ack_o;
   logic             busy_o;

   modport slave (
      input  irq_req_i, mie_i, ready_i, mret_i,
      output trap_o, irq_cause_o, irq_ack_o, busy_o
   );

   modport master (
      output irq_req_i, mie_i, ready_i, mret_i,
      input  trap_o, irq_cause_o, irq_ack_o, busy_o
   );
endinterface

`default_nettype wire

// File: rtl/irq_controller.sv
// ============================================================================
// Module   : irq_controller
// Brief    : Fixed-priority machine external interrupt controller feeding the
//            CSR trap path; one interrupt per mret round trip.
//            Define IRQ_SYNC_EN to add a 2-flop synchronizer per request line.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_controller #(
   parameter int N_IRQ = 16
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   irq_controller_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [3:0]       idx_q, idx_d;
   logic [31:0]      cause_q, cause_d;

   logic [N_IRQ-1:0] s_req;
   logic [31:0]      mie_hi;
   logic [N_IRQ-1:0] pend;
   logic [15:0]      pend_ext;
   logic             any_pend;
   logic [3:0]       win_idx;
   logic             trap;
   logic [N_IRQ-1:0] ack;
   logic             unused_mie;

`ifdef IRQ_SYNC_EN
   logic [N_IRQ-1:0] sync1_q, sync2_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= bus.irq_req_i;
         sync2_q <= sync1_q;
      end
   end

   assign s_req = sync2_q;
`else
   assign s_req = bus.irq_req_i;
`endif

   assign mie_hi     = bus.mie_i >> 16;
   assign pend       = s_req & mie_hi[N_IRQ-1:0];
   assign pend_ext   = 16'(pend);
   assign any_pend   = |pend;
   assign unused_mie = ^{bus.mie_i[15:0], mie_hi[31:N_IRQ]};

   // Lowest index wins: scan downward so the last hit is the smallest index.
   always_comb begin
      win_idx = 4'd0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (pend[i]) begin
            win_idx = 4'(i);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cause_d = cause_q;
      trap    = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_pend) begin
               idx_d   = win_idx;
               cause_d = {1'b1, 26'b0, 5'd16 + {1'b0, win_idx}};
               state_d = REQ;
            end
         end
         REQ: begin
            // A withdrawn or masked winner drops the request even if ready.
            if (!pend_ext[idx_q]) begin
               state_d = IDLE;
            end else if (bus.ready_i) begin
               trap    = 1'b1;
               state_d = SERVICE;
            end
         end
         SERVICE: begin
            if (bus.mret_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ack = '0;
      for (int i = 0; i < N_IRQ; i++) begin
         ack[i] = trap && (idx_q == 4'(i));
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         idx_q   <= 4'd0;
         cause_q <= 32'h0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cause_q <= cause_d;
      end
   end

   assign bus.trap_o      = trap;
   assign bus.irq_ack_o   = ack;
   assign bus.irq_cause_o = cause_q;
   assign bus.busy_o      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_irq_controller.sv
// ============================================================================
// Module   : tb_irq_controller
// Brief    : Directed self-checking bench for irq_controller (both builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_irq_controller;

`ifdef IRQ_SYNC_EN
   localparam int SL = 2;
`else
   localparam int SL = 0;
`endif

   logic clk = 1'b0;
   logic rst_ni;
   int   n_checks = 0;
   int   n_fail   = 0;

   irq_controller_if #(.N_IRQ(16)) bus ();

   irq_controller #(.N_IRQ(16)) dut (
      .clk_i  (clk),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   task automatic close_service();
      bus.irq_req_i = 16'h0;
      steps(3);
      bus.mret_i = 1'b1;
      step();
      bus.mret_i = 1'b0;
      #1;
      check("close_busy", 32'(bus.busy_o), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_ni        = 1'b0;
      bus.irq_req_i = 16'h0;
      bus.mie_i     = 32'h0;
      bus.ready_i   = 1'b0;
      bus.mret_i    = 1'b0;
      steps(2);
      #1;
      check("rst_busy",  32'(bus.busy_o),    32'h0);
      check("rst_trap",  32'(bus.trap_o),    32'h0);
      check("rst_ack",   32'(bus.irq_ack_o), 32'h0);
      check("rst_cause", bus.irq_cause_o,    32'h0);
      rst_ni = 1'b1;
      step();

      // Basic single interrupt on line 0
      bus.mie_i     = 32'h0001_0000;
      bus.ready_i   = 1'b1;
      bus.irq_req_i = 16'h0001;
      steps(SL);
      #1;
      check("basic_early", 32'(bus.trap_o), 32'h0);
      step();
      #1;
      check("basic_trap",  32'(bus.trap_o),    32'h1);
      check("basic_cause", bus.irq_cause_o,    32'h8000_0010);
      check("basic_ack",   32'(bus.irq_ack_o), 32'h0001);
      check("basic_busy",  32'(bus.busy_o),    32'h1);
      step();
      #1;
      check("basic_one_cycle", 32'(bus.trap_o),    32'h0);
      check("basic_ack_off",   32'(bus.irq_ack_o), 32'h0);
      check("basic_service",   32'(bus.busy_o),    32'h1);
      bus.irq_req_i = 16'h0;
      steps(3);
      #1;
      check("basic_hold_busy", 32'(bus.busy_o), 32'h1);
      bus.mret_i = 1'b1;
      #1;
      check("basic_mret_same_cycle", 32'(bus.busy_o), 32'h1);
      step();
      bus.mret_i = 1'b0;
      #1;
      check("basic_idle", 32'(bus.busy_o), 32'h0);

      // Priority and mask
      bus.mie_i     = 32'h0024_0000;
      bus.irq_req_i = 16'h0024;
      steps(1 + SL);
      #1;
      check("prio_trap",  32'(bus.trap_o),    32'h1);
      check("prio_cause", bus.irq_cause_o,    32'h8000_0012);
      check("prio_ack",   32'(bus.irq_ack_o), 32'h0004);
      step();
      bus.mie_i  = 32'h0020_0000;
      bus.mret_i = 1'b1;
      step();
      bus.mret_i = 1'b0;
      #1;
      check("mask_idle", 32'(bus.busy_o), 32'h0);
      check("mask_gap",  32'(bus.trap_o), 32'h0);
      step();
      #1;
      check("mask_trap",  32'(bus.trap_o),    32'h1);
      check("mask_cause", bus.irq_cause_o,    32'h8000_0015);
      check("mask_ack",   32'(bus.irq_ack_o), 32'h0020);
      step();
      close_service();

      // Stall on line 7, line 1 rises, then line 7 withdraws
      bus.ready_i   = 1'b0;
      bus.mie_i     = 32'h0082_0000;
      bus.irq_req_i = 16'h0080;
      steps(1 + SL);
      #1;
      check("stall_busy",  32'(bus.busy_o), 32'h1);
      check("stall_trap",  32'(bus.trap_o), 32'h0);
      check("stall_cause", bus.irq_cause_o, 32'h8000_0017);
      bus.irq_req_i = 16'h0082;
      for (int i = 0; i < 3; i++) begin
         step();
         #1;
         check("stall_no_trap", 32'(bus.trap_o), 32'h0);
         check("stall_no_rearb", bus.irq_cause_o, 32'h8000_0017);
      end
      bus.irq_req_i = 16'h0002;
      steps(1 + SL);
      #1;
      check("withdraw_idle", 32'(bus.busy_o), 32'h0);
      check("withdraw_trap", 32'(bus.trap_o), 32'h0);
      bus.ready_i = 1'b1;
      step();
      #1;
      check("line1_trap",  32'(bus.trap_o),    32'h1);
      check("line1_cause", bus.irq_cause_o,    32'h8000_0011);
      check("line1_ack",   32'(bus.irq_ack_o), 32'h0002);

      // Blocking during SERVICE, then trap 2 cycles after mret
      step();
      bus.irq_req_i = 16'h0080;
      for (int i = 0; i < 4; i++) begin
         step();
         #1;
         check("block_no_trap", 32'(bus.trap_o), 32'h0);
         check("block_busy",    32'(bus.busy_o), 32'h1);
      end
      bus.mret_i = 1'b1;
      step();
      bus.mret_i = 1'b0;
      #1;
      check("block_idle", 32'(bus.busy_o), 32'h0);
      check("block_gap",  32'(bus.trap_o), 32'h0);
      step();
      #1;
      check("block_trap",  32'(bus.trap_o),    32'h1);
      check("block_cause", bus.irq_cause_o,    32'h8000_0017);
      check("block_ack",   32'(bus.irq_ack_o), 32'h0080);
      step();
      close_service();

      // Mask removal beats ready in the same cycle
      bus.ready_i   = 1'b0;
      bus.mie_i     = 32'h0008_0000;
      bus.irq_req_i = 16'h0008;
      steps(1 + SL);
      #1;
      check("prec_busy",  32'(bus.busy_o), 32'h1);
      check("prec_cause", bus.irq_cause_o, 32'h8000_0013);
      bus.mie_i   = 32'h0;
      bus.ready_i = 1'b1;
      #1;
      check("prec_trap", 32'(bus.trap_o),    32'h0);
      check("prec_ack",  32'(bus.irq_ack_o), 32'h0);
      step();
      #1;
      check("prec_idle", 32'(bus.busy_o), 32'h0);
      step();
      #1;
      check("prec_stay_idle", 32'(bus.busy_o), 32'h0);

      // Asynchronous reset mid-REQ
      bus.ready_i = 1'b0;
      bus.mie_i   = 32'h0008_0000;
      step();
      #1;
      check("rq_busy", 32'(bus.busy_o), 32'h1);
      rst_ni = 1'b0;
      #1;
      check("arst_busy",  32'(bus.busy_o),    32'h0);
      check("arst_trap",  32'(bus.trap_o),    32'h0);
      check("arst_ack",   32'(bus.irq_ack_o), 32'h0);
      check("arst_cause", bus.irq_cause_o,    32'h0);
      bus.ready_i = 1'b1;
      step();
      #1;
      check("arst_held_trap", 32'(bus.trap_o), 32'h0);
      rst_ni = 1'b1;
      #1;
      check("arst_release_trap", 32'(bus.trap_o), 32'h0);
      steps(SL);
      #1;
      check("arst_early", 32'(bus.trap_o), 32'h0);
      step();
      #1;
      check("arst_retrap", 32'(bus.trap_o),    32'h1);
      check("arst_cause2", bus.irq_cause_o,    32'h8000_0013);
      check("arst_ack2",   32'(bus.irq_ack_o), 32'h0008);
      step();
      close_service();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
